shift_exec_stage: RTL and testbench

- Registered execute stage wrapped around the combinational barrel shifter.
- Accepts shift operations from the decode stage on a valid/ready handshake. Computes the result plus carry, zero and negative flags, and presents them downstream through a 2-entry skid buffer.
- Provides full throughput (1 op/cycle) and stalls cleanly on downstream backpressure without dropping or duplicating ops.

---
 rtl/shift_exec_stage_pkg.sv | 20 ++
 rtl/shift_exec_stage_barrel.sv | 36 +++
 rtl/shift_exec_stage.sv | 145 ++++++++++++++
 tb/tb_shift_exec_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_exec_stage_pkg.sv
// Shared widths, shift opcodes and skid-buffer occupancy encoding for the
// shift execute stage.
package shift_exec_stage_pkg;

  localparam int REG_WIDTH = 32;
  localparam int SA_WIDTH  = 5;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b110;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } occ_state_e;

endpackage

// File: rtl/shift_exec_stage_barrel.sv
// Combinational barrel shifter: SLL/ROL/SRL/ROR/SRA, flags any other opcode
// as illegal and returns zero for it.
module shift_exec_stage_barrel
  import shift_exec_stage_pkg::*;
#(
  parameter int W   = REG_WIDTH,
  parameter int SAW = SA_WIDTH
) (
  input  logic [2:0]     op,
  input  logic [SAW-1:0] sa,
  input  logic [W-1:0]   data,
  output logic [W-1:0]   result,
  output logic           err
);

  logic [W-1:0] rol_res;
  logic [W-1:0] ror_res;

  // A shift by W yields zero, so sa=0 rotates cleanly to the operand itself.
  assign rol_res = (data << sa) | (data >> (W - int'(sa)));
  assign ror_res = (data >> sa) | (data << (W - int'(sa)));

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_SLL:  result = data << sa;
      OP_ROL:  result = rol_res;
      OP_SRL:  result = data >> sa;
      OP_ROR:  result = ror_res;
      OP_SRA:  result = W'($signed(data) >>> sa);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Registered shift execute stage with a 2-entry skid buffer on the output.
// Optional SHIFT_EXEC_STATS_EN adds saturating stat_ops/stat_err counters.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int REG_W = REG_WIDTH,
  parameter int SA_W  = SA_WIDTH,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [SA_W-1:0]      in_sa,
  input  logic [REG_W-1:0]     in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_W-1:0]     out_data,
  output logic                 out_carry,
  output logic                 out_zero,
  output logic                 out_neg,
  output logic                 out_err,
  output logic [TAG_WIDTH-1:0] out_tag
`ifdef SHIFT_EXEC_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_err
`endif
);

  // Entry layout: {data, carry, zero, neg, err, tag}
  localparam int EW = REG_W + 4 + TAG_WIDTH;

  occ_state_e state, next_state;
  logic load_main, load_skid, skid_to_main;
  logic in_xfer, out_xfer;

  logic [REG_W-1:0] shift_res;
  logic             shift_err;
  logic             carry;
  logic [SA_W-1:0]  sll_idx;
  logic [SA_W-1:0]  sr_idx;
  logic [EW-1:0]    new_entry, main_q, skid_q;

  shift_exec_stage_barrel #(
    .W   (REG_W),
    .SAW (SA_W)
  ) u_barrel (
    .op     (in_op),
    .sa     (in_sa),
    .data   (in_data),
    .result (shift_res),
    .err    (shift_err)
  );

  assign sll_idx = SA_W'(REG_W - int'(in_sa));
  assign sr_idx  = in_sa - SA_W'(1);

  always_comb begin
    carry = 1'b0;
    if (in_sa != '0) begin
      case (in_op)
        OP_SLL:         carry = in_data[sll_idx];
        OP_SRL, OP_SRA: carry = in_data[sr_idx];
        OP_ROL:         carry = shift_res[0];
        OP_ROR:         carry = shift_res[REG_W-1];
        default:        carry = 1'b0;
      endcase
    end
  end

  assign new_entry = {shift_res, carry, (shift_res == '0), shift_res[REG_W-1],
                      shift_err, in_tag};

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= next_state;
  end

  // in_ready comes straight from the state register, never from out_ready.
  always_comb begin
    next_state   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    in_ready     = (state != FULL);
    out_valid    = (state != EMPTY);
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          next_state = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          next_state   = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= new_entry;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= new_entry;
    end
  end

  assign {out_data, out_carry, out_zero, out_neg, out_err, out_tag} = main_q;

`ifdef SHIFT_EXEC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_err <= '0;
    end else if (out_xfer) begin
      if (stat_ops != 16'hFFFF)            stat_ops <= stat_ops + 16'd1;
      if (out_err && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage: shifts, boundaries,
// backpressure, asynchronous reset and back-to-back throughput.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_sa;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic        out_neg;
  logic        out_err;
  logic [3:0]  out_tag;
`ifdef SHIFT_EXEC_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_err;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_sa     (in_sa),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_err   (out_err),
    .out_tag   (out_tag)
`ifdef SHIFT_EXEC_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_err  (stat_err)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One isolated op through an empty stage with out_ready high.
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] sa, input logic [31:0] data,
                               input logic [3:0] tag, input logic [31:0] exp_data,
                               input logic exp_carry, input logic exp_zero,
                               input logic exp_neg, input logic exp_err);
    in_valid  = 1'b1;
    in_op     = op;
    in_sa     = sa;
    in_data   = data;
    in_tag    = tag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("dir_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("dir_data",  out_data, exp_data);
    checkOutput("dir_carry", {31'b0, out_carry}, {31'b0, exp_carry});
    checkOutput("dir_zero",  {31'b0, out_zero},  {31'b0, exp_zero});
    checkOutput("dir_neg",   {31'b0, out_neg},   {31'b0, exp_neg});
    checkOutput("dir_err",   {31'b0, out_err},   {31'b0, exp_err});
    checkOutput("dir_tag",   {28'b0, out_tag},   {28'b0, tag});
    @(posedge clk); #1;
    checkOutput("dir_drain", {31'b0, out_valid}, 32'd0);
  endtask

  logic        bp_pattern [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1};
  logic [2:0]  tp_op   [8] = '{3'b000, 3'b010, 3'b101, 3'b001, 3'b011, 3'b110, 3'b010, 3'b000};
  logic [4:0]  tp_sa   [8] = '{5'd4, 5'd8, 5'd3, 5'd8, 5'd8, 5'd31, 5'd31, 5'd16};
  logic [31:0] tp_data [8] = '{32'h0000_000F, 32'hFF00_0000, 32'h1234_5678, 32'h1234_5678,
                               32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'h0000_ABCD};
  logic [31:0] tp_exp  [8] = '{32'h0000_00F0, 32'h00FF_0000, 32'h0000_0000, 32'h3456_7812,
                               32'h7812_3456, 32'hFFFF_FFFF, 32'h0000_0001, 32'hABCD_0000};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_sa     = 5'd0;
    in_data   = 32'd0;
    in_tag    = 4'd0;
    out_ready = 1'b0;

    #12;
    checkOutput("reset_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data",  out_data, 32'd0);
    checkOutput("reset_flags", {28'b0, out_carry, out_zero, out_neg, out_err}, 32'd0);
    checkOutput("reset_out_tag",   {28'b0, out_tag},   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // op, sa, data, tag, exp data, carry, zero, neg, err
    applyStimulus(3'b000, 5'd1,  32'h8000_0001, 4'd1, 32'h0000_0002, 1, 0, 0, 0);
    applyStimulus(3'b110, 5'd4,  32'hF000_0000, 4'd2, 32'hFF00_0000, 0, 0, 1, 0);
    applyStimulus(3'b011, 5'd1,  32'h0000_0001, 4'd3, 32'h8000_0000, 1, 0, 1, 0);
    applyStimulus(3'b000, 5'd0,  32'h1234_5678, 4'd4, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(3'b001, 5'd0,  32'h1234_5678, 4'd5, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(3'b010, 5'd0,  32'h1234_5678, 4'd6, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(3'b011, 5'd0,  32'h1234_5678, 4'd7, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(3'b110, 5'd0,  32'hA5A5_A5A5, 4'd8, 32'hA5A5_A5A5, 0, 0, 1, 0);
    applyStimulus(3'b010, 5'd1,  32'h0000_0001, 4'd9, 32'h0000_0000, 1, 1, 0, 0);
    applyStimulus(3'b001, 5'd31, 32'h0000_0002, 4'd10, 32'h0000_0001, 1, 0, 0, 0);
    applyStimulus(3'b000, 5'd31, 32'h0000_0003, 4'd11, 32'h8000_0000, 1, 0, 1, 0);
    applyStimulus(3'b010, 5'd31, 32'h8000_0000, 4'd12, 32'h0000_0001, 0, 0, 0, 0);
    applyStimulus(3'b110, 5'd31, 32'h4000_0000, 4'd13, 32'h0000_0000, 1, 1, 0, 0);
    applyStimulus(3'b100, 5'd3,  32'hFFFF_FFFF, 4'd14, 32'h0000_0000, 0, 1, 0, 1);
    applyStimulus(3'b111, 5'd7,  32'h1234_5678, 4'd15, 32'h0000_0000, 0, 1, 0, 1);

    // Backpressure: occupancy model drives expectations for every cycle.
    begin
      int sent = 0;
      int cnt = 0;
      int dut_recv = 0;
      int exp_q[$];
      logic in_x, out_x;
      for (int cyc = 0; cyc < 60 && dut_recv < 6; cyc++) begin
        in_valid  = (sent < 6);
        in_op     = 3'b000;
        in_sa     = 5'(sent);
        in_data   = 32'h1;
        in_tag    = 4'(sent);
        out_ready = bp_pattern[cyc % 10];
        #2;
        checkOutput("bp_in_ready",  {31'b0, in_ready},  {31'b0, cnt != 2});
        checkOutput("bp_out_valid", {31'b0, out_valid}, {31'b0, cnt != 0});
        if (cnt != 0) begin
          checkOutput("bp_tag",  {28'b0, out_tag}, 32'(exp_q[0]));
          checkOutput("bp_data", out_data, 32'h1 << exp_q[0]);
        end
        if (out_valid && out_ready) dut_recv++;
        in_x  = in_valid && (cnt != 2);
        out_x = out_ready && (cnt != 0);
        if (out_x) void'(exp_q.pop_front());
        if (in_x) begin
          exp_q.push_back(sent);
          sent++;
        end
        cnt = cnt + int'(in_x) - int'(out_x);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checkOutput("bp_recv_count", 32'(dut_recv), 32'd6);
      repeat (2) begin
        @(posedge clk); #1;
        checkOutput("bp_no_dup", {31'b0, out_valid}, 32'd0);
      end
    end

    // Fill both entries, then reset asynchronously between clock edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'b010;
    in_sa     = 5'd0;
    in_data   = 32'hAAAA_5555;
    in_tag    = 4'd7;
    @(posedge clk); #1;
    in_tag = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("rst_pre_full", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_async_ready", {31'b0, in_ready},  32'd1);
    checkOutput("rst_async_data",  out_data, 32'd0);
    checkOutput("rst_async_flags", {28'b0, out_carry, out_zero, out_neg, out_err}, 32'd0);
    checkOutput("rst_async_tag",   {28'b0, out_tag}, 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rst_no_stale", {31'b0, out_valid}, 32'd0);
    end

    // Back-to-back ops with out_ready high: one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checkOutput("tp_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("tp_data",  out_data, tp_exp[i-1]);
        checkOutput("tp_err",   {31'b0, out_err}, {31'b0, (i - 1) == 2});
        checkOutput("tp_tag",   {28'b0, out_tag}, 32'(8 + i - 1));
      end
      if (i < 8) begin
        in_valid = 1'b1;
        in_op    = tp_op[i];
        in_sa    = tp_sa[i];
        in_data  = tp_data[i];
        in_tag   = 4'(8 + i);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    checkOutput("tp_drain", {31'b0, out_valid}, 32'd0);
`ifdef SHIFT_EXEC_STATS_EN
    checkOutput("stat_ops", {16'b0, stat_ops}, 32'd8);
    checkOutput("stat_err", {16'b0, stat_err}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
